// File: rtl/color_mask_stats.sv
// Three-stage RGB threshold mask with per-frame hit count and bounding box.
// All three stages advance together; a stalled output holds the whole pipe.
module color_mask_stats #(
  parameter int PIX_W    = 8,
  parameter int WIDTH    = 768,
  parameter int HEIGHT   = 512,
  parameter int COORD_W  = 11,
  parameter int CNT_W    = 19,
  parameter int MODE     = 0,
  parameter int THRESH_R = 180,
  parameter int THRESH_G = 180,
  parameter int THRESH_B = 180,
  parameter int THRESH_Y = 180,
  parameter int MASK_VAL = 77
) (
  input  logic               CAMERA_CLK,
  input  logic               rst,
  input  logic [PIX_W-1:0]   inputPixel_R,
  input  logic [PIX_W-1:0]   inputPixel_G,
  input  logic [PIX_W-1:0]   inputPixel_B,
  input  logic [COORD_W-1:0] coordinate_X,
  input  logic [COORD_W-1:0] coordinate_Y,
  input  logic               readWrite,
  output logic               in_ready,
  output logic [PIX_W-1:0]   outputPixel,
  output logic               writeBackImage,
  input  logic               out_ready,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [PIX_W-1:0]   cfg_data,
  output logic               frame_done,
  output logic [CNT_W-1:0]   hit_count,
  output logic               bbox_valid,
  output logic [COORD_W-1:0] bbox_xmin,
  output logic [COORD_W-1:0] bbox_xmax,
  output logic [COORD_W-1:0] bbox_ymin,
  output logic [COORD_W-1:0] bbox_ymax
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic [PIX_W-1:0]   r, g, b, y;
    logic [COORD_W-1:0] x, yc;
  } s1_t;

  typedef struct packed {
    logic               hit;
    logic [COORD_W-1:0] x, yc;
  } hit_t;

  logic [STAGES:1]         vld_pipe;
  logic                    en;
  s1_t                     s1, s1_d;
  hit_t                    s2, s2_d, s3;
  logic [3:0][PIX_W-1:0]   thr;
  logic                    gt_r, gt_g, gt_b, gt_y;

  assign en             = !vld_pipe[STAGES] || out_ready;
  assign in_ready       = en;
  assign writeBackImage = vld_pipe[STAGES];

  always_comb begin
    s1_d    = '0;
    s1_d.r  = inputPixel_R;
    s1_d.g  = inputPixel_G;
    s1_d.b  = inputPixel_B;
    // 16-bit weighted sum tops out at 255*256, so the >>8 result always fits
    s1_d.y  = PIX_W'((16'd77 * 16'(inputPixel_R) + 16'd150 * 16'(inputPixel_G)
                    + 16'd29 * 16'(inputPixel_B)) >> 8);
    s1_d.x  = coordinate_X;
    s1_d.yc = coordinate_Y;
  end

  assign gt_r = s1.r > thr[0];
  assign gt_g = s1.g > thr[1];
  assign gt_b = s1.b > thr[2];
  assign gt_y = s1.y > thr[3];

  always_comb begin
    s2_d.x  = s1.x;
    s2_d.yc = s1.yc;
    case (MODE)
      0:       s2_d.hit = gt_r;
      1:       s2_d.hit = gt_g;
      3:       s2_d.hit = gt_y;
      4:       s2_d.hit = gt_r && gt_g && gt_b;
      5:       s2_d.hit = gt_r || gt_g || gt_b;
      default: s2_d.hit = gt_b;
    endcase
  end

  // Writes land on the edge; a compare on that same edge still sees the old value
  always_ff @(posedge CAMERA_CLK) begin
    if (!rst)
      thr <= {PIX_W'(THRESH_Y), PIX_W'(THRESH_B), PIX_W'(THRESH_G), PIX_W'(THRESH_R)};
    else if (cfg_we)
      thr[cfg_sel] <= cfg_data;
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (!rst) begin
      vld_pipe    <= '0;
      outputPixel <= '0;
    end else if (en) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], readWrite};
      outputPixel <= (vld_pipe[STAGES-1] && s2.hit) ? PIX_W'(MASK_VAL) : '0;
    end
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (en) begin
      s1 <= s1_d;
      s2 <= s2_d;
      s3 <= s2;
    end
  end

  logic                xfer, last;
  logic [CNT_W-1:0]    acc_cnt, nxt_cnt;
  logic [COORD_W-1:0]  acc_x0, acc_x1, acc_y0, acc_y1;
  logic [COORD_W-1:0]  nxt_x0, nxt_x1, nxt_y0, nxt_y1;

  assign xfer = vld_pipe[STAGES] && out_ready;
  assign last = (s3.x == COORD_W'(WIDTH-1)) && (s3.yc == COORD_W'(HEIGHT-1));

  always_comb begin
    nxt_cnt = acc_cnt;
    nxt_x0  = acc_x0;
    nxt_x1  = acc_x1;
    nxt_y0  = acc_y0;
    nxt_y1  = acc_y1;
    if (s3.hit) begin
      nxt_cnt = acc_cnt + CNT_W'(1);
      if (s3.x  < acc_x0) nxt_x0 = s3.x;
      if (s3.x  > acc_x1) nxt_x1 = s3.x;
      if (s3.yc < acc_y0) nxt_y0 = s3.yc;
      if (s3.yc > acc_y1) nxt_y1 = s3.yc;
    end
  end

  // Frame-end pixel is folded in, published, and the accumulators restart
  always_ff @(posedge CAMERA_CLK) begin
    if (!rst) begin
      acc_cnt    <= '0;
      acc_x0     <= '1;
      acc_x1     <= '0;
      acc_y0     <= '1;
      acc_y1     <= '0;
      frame_done <= 1'b0;
      hit_count  <= '0;
      bbox_valid <= 1'b0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
    end else begin
      frame_done <= xfer && last;
      if (xfer) begin
        if (last) begin
          hit_count  <= nxt_cnt;
          bbox_valid <= nxt_cnt != '0;
          bbox_xmin  <= nxt_x0;
          bbox_xmax  <= nxt_x1;
          bbox_ymin  <= nxt_y0;
          bbox_ymax  <= nxt_y1;
          acc_cnt    <= '0;
          acc_x0     <= '1;
          acc_x1     <= '0;
          acc_y0     <= '1;
          acc_y1     <= '0;
        end else begin
          acc_cnt <= nxt_cnt;
          acc_x0  <= nxt_x0;
          acc_x1  <= nxt_x1;
          acc_y0  <= nxt_y0;
          acc_y1  <= nxt_y1;
        end
      end
    end
  end
endmodule

// File: tb/tb_color_mask_stats.sv
// Scoreboard bench: six instances (modes 0,1,3,4,5,7) share one stimulus stream
// on a 4x2 frame; a reference model predicts mask pixels and frame statistics.
module tb_color_mask_stats;
  localparam int NI = 6, PW = 8, CW = 11, NW = 19, W = 4, H = 2;
  localparam logic [3*NI-1:0] MODES_P = {3'd7, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0};

  logic CAMERA_CLK = 1'b0, rst = 1'b0;
  always #5 CAMERA_CLK = ~CAMERA_CLK;

  logic [PW-1:0] pr, pg, pb, cfg_data;
  logic [CW-1:0] px, py;
  logic          readWrite, out_ready, cfg_we;
  logic [1:0]    cfg_sel;

  logic          in_rdy [NI];
  logic [PW-1:0] opix   [NI];
  logic          wbi    [NI];
  logic          fd     [NI];
  logic [NW-1:0] hc     [NI];
  logic          bv     [NI];
  logic [CW-1:0] bx0 [NI], bx1 [NI], by0 [NI], by1 [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    color_mask_stats #(
      .PIX_W(PW), .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CNT_W(NW),
      .MODE(int'(MODES_P[gi*3 +: 3]))
    ) u_dut (
      .CAMERA_CLK(CAMERA_CLK), .rst(rst),
      .inputPixel_R(pr), .inputPixel_G(pg), .inputPixel_B(pb),
      .coordinate_X(px), .coordinate_Y(py), .readWrite(readWrite),
      .in_ready(in_rdy[gi]), .outputPixel(opix[gi]), .writeBackImage(wbi[gi]),
      .out_ready(out_ready), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .frame_done(fd[gi]), .hit_count(hc[gi]), .bbox_valid(bv[gi]),
      .bbox_xmin(bx0[gi]), .bbox_xmax(bx1[gi]), .bbox_ymin(by0[gi]), .bbox_ymax(by1[gi])
    );
  end

  typedef struct packed {
    logic [NW-1:0] cnt;
    logic          v;
    logic [CW-1:0] x0, x1, y0, y1;
  } st_t;
  typedef st_t [NI-1:0] stv_t;

  int              n_chk, n_fail;
  int              thr [4];
  st_t             acc [NI];
  logic [NI-1:0]   pq [$];
  stv_t            sq [$];
  int              bp_mode;
  bit              mon_en;
  int              rpos;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic st_t fresh();
    st_t f;
    f.cnt = '0; f.v = 1'b0; f.x0 = '1; f.x1 = '0; f.y0 = '1; f.y1 = '0;
    return f;
  endfunction

  function automatic bit ref_hit(input int mode, input int r, input int g, input int b);
    int y;
    y = (77*r + 150*g + 29*b) / 256;
    case (mode)
      0: return r > thr[0];
      1: return g > thr[1];
      3: return y > thr[3];
      4: return (r > thr[0]) && (g > thr[1]) && (b > thr[2]);
      5: return (r > thr[0]) || (g > thr[1]) || (b > thr[2]);
      default: return b > thr[2];
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) thr[i] = 180;
    for (int i = 0; i < NI; i++) acc[i] = fresh();
    pq.delete();
    sq.delete();
  endfunction

  function automatic void model_push(input int r, input int g, input int b, input int x, input int y);
    logic [NI-1:0] h;
    stv_t fr;
    for (int i = 0; i < NI; i++) begin
      h[i] = ref_hit(int'(MODES_P[i*3 +: 3]), r, g, b);
      if (h[i]) begin
        acc[i].cnt++;
        if (x < int'(acc[i].x0)) acc[i].x0 = CW'(x);
        if (x > int'(acc[i].x1)) acc[i].x1 = CW'(x);
        if (y < int'(acc[i].y0)) acc[i].y0 = CW'(y);
        if (y > int'(acc[i].y1)) acc[i].y1 = CW'(y);
      end
    end
    pq.push_back(h);
    if (x == W-1 && y == H-1) begin
      for (int i = 0; i < NI; i++) begin
        fr[i]   = acc[i];
        fr[i].v = acc[i].cnt != 0;
        acc[i]  = fresh();
      end
      sq.push_back(fr);
    end
  endfunction

  task automatic cyc();
    @(posedge CAMERA_CLK);
    #1;
  endtask

  task automatic send(input int r, input int g, input int b, input int x, input int y);
    bit ok = 1'b0;
    pr = PW'(r); pg = PW'(g); pb = PW'(b); px = CW'(x); py = CW'(y);
    readWrite = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CAMERA_CLK);
      ok = in_rdy[0];
      cyc();
    end
    readWrite = 1'b0;
    chk("accept_timeout", ok, 1);
    if (ok) model_push(r, g, b, x, y);
  endtask

  task automatic send_rand();
    int x, y;
    x = rpos % W;
    y = (rpos / W) % H;
    rpos++;
    if ($urandom_range(0, 9) == 0) begin
      x = $urandom_range(0, 5);
      y = $urandom_range(0, 3);
    end
    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), x, y);
  endtask

  task automatic cfg(input int sel, input int val);
    cfg_sel = 2'(sel); cfg_data = PW'(val); cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
    thr[sel] = val;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (pq.size() != 0 || sq.size() != 0); t++) cyc();
    chk("drain_pending", pq.size() + sq.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    repeat (n) cyc();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_wbi[%0d]", i), wbi[i], 0);
      chk($sformatf("rst_pix[%0d]", i), opix[i], 0);
      chk($sformatf("rst_fd[%0d]", i), fd[i], 0);
      chk($sformatf("rst_hc[%0d]", i), hc[i], 0);
      chk($sformatf("rst_bv[%0d]", i), bv[i], 0);
      chk($sformatf("rst_bbox[%0d]", i), {bx0[i], bx1[i], by0[i], by1[i]}, 0);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("rst_in_ready[%0d]", i), in_rdy[i], 1);
  endtask

  // Backpressure pattern generator
  initial begin
    forever begin
      @(posedge CAMERA_CLK);
      #1;
      case (bp_mode)
        1:       out_ready = !out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output transfer and each frame_done
  logic [PW-1:0] hold_pix [NI];
  bit            held;
  always @(negedge CAMERA_CLK) begin
    logic [NI-1:0] h;
    stv_t fr;
    if (rst && mon_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("in_ready[%0d]", i), in_rdy[i], out_ready || !wbi[i]);
        chk($sformatf("wbi_agree[%0d]", i), wbi[i], wbi[0]);
        chk($sformatf("fd_agree[%0d]", i), fd[i], fd[0]);
        if (held) chk($sformatf("stall_stable[%0d]", i), opix[i], hold_pix[i]);
      end
      held = wbi[0] && !out_ready;
      for (int i = 0; i < NI; i++) hold_pix[i] = opix[i];
      if (wbi[0] && out_ready) begin
        chk("out_expected", pq.size() != 0, 1);
        if (pq.size() != 0) begin
          h = pq.pop_front();
          for (int i = 0; i < NI; i++)
            chk($sformatf("pix[%0d]", i), opix[i], h[i] ? 77 : 0);
        end
      end
      if (fd[0]) begin
        chk("frame_expected", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          fr = sq.pop_front();
          for (int i = 0; i < NI; i++) begin
            chk($sformatf("hit_count[%0d]", i), hc[i], fr[i].cnt);
            chk($sformatf("bbox_valid[%0d]", i), bv[i], fr[i].v);
            chk($sformatf("xmin[%0d]", i), bx0[i], fr[i].x0);
            chk($sformatf("xmax[%0d]", i), bx1[i], fr[i].x1);
            chk($sformatf("ymin[%0d]", i), by0[i], fr[i].y0);
            chk($sformatf("ymax[%0d]", i), by1[i], fr[i].y1);
          end
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0t expected < 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; rpos = 0;
    readWrite = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    pr = '0; pg = '0; pb = '0; px = '0; py = '0;
    bp_mode = 0; mon_en = 1'b0; held = 1'b0;
    cyc();
    do_reset(3);
    mon_en = 1'b1;

    // single-channel modes: strict compare at 180
    send(181, 0, 0, 0, 0);
    send(180, 255, 255, 0, 0);
    send(0, 181, 181, 0, 0);
    drain();

    // luma 152 vs 150, then vs 152
    cfg(3, 150);
    send(100, 200, 50, 0, 0);
    drain();
    cfg(3, 152);
    send(100, 200, 50, 0, 0);
    drain();

    // AND / OR at 100/100/100
    cfg(0, 100); cfg(1, 100); cfg(2, 100);
    send(101, 101, 100, 0, 0);
    send(101, 101, 101, 0, 0);
    drain();

    // write on the compare edge still sees the old threshold
    send(150, 0, 0, 0, 0);
    cfg(0, 200);
    send(150, 0, 0, 0, 0);
    drain();

    // clean 4x2 frame with hits at (1,0) and (3,1), then an all-miss frame
    do_reset(2);
    for (int p = 0; p < W*H; p++)
      send((p == 1 || p == 7) ? 200 : 0, 0, 0, p % W, p / W);
    for (int p = 0; p < W*H; p++)
      send(0, 0, 0, p % W, p / W);
    drain();

    // alternating backpressure
    bp_mode = 1;
    for (int k = 0; k < 20; k++) send_rand();
    bp_mode = 0;
    drain();

    // random traffic with random thresholds
    for (int bt = 0; bt < 3; bt++) begin
      for (int s = 0; s < 4; s++) cfg(s, $urandom_range(60, 200));
      bp_mode = 2;
      for (int k = 0; k < 60; k++) send_rand();
      bp_mode = 0;
      drain();
    end

    // reset with two pixels in flight; thresholds must come back to 180
    cfg(0, 50);
    send(120, 10, 10, 0, 0);
    send(120, 10, 10, 1, 0);
    do_reset(1);
    send(181, 0, 0, 0, 0);
    send(180, 0, 0, 1, 0);
    for (int p = 0; p < W*H; p++) send_rand();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
